wb_arbiter: RTL and testbench

Writeback arbiter between the execution units (RS/ALU, LSB, branch unit) and the single result-submit port of the reorder buffer. Each requester gets a small per-source FIFO, so a result handed off in one cycle is never lost when several units finish together. A round-robin scheduler drains one result per cycle into the ROB. Flushes on branch mispredict.

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 76 +++++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_pkg
// Brief    : Shared widths, requester indices and null-tag value for the
//            writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

  localparam int c_NUM_REQ   = 3;
  localparam int c_TAG_W     = 4;
  localparam int c_DATA_W    = 32;
  localparam int c_BUF_DEPTH = 2;

  localparam int c_WB_SRC_RS  = 0;
  localparam int c_WB_SRC_LSB = 1;
  localparam int c_WB_SRC_BR  = 2;

  // ROB tag 0 means "no instruction"
  localparam int c_NULL_TAG = 0;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Per-requester result FIFO with enable-gated push/pop and flush.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [TAG_W-1:0]         i_push_tag,
  input  logic [DATA_W-1:0]        i_push_val,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [TAG_W-1:0]         o_head_tag,
  output logic [DATA_W-1:0]        o_head_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  logic [TAG_W-1:0]  r_tag [DEPTH];
  logic [DATA_W-1:0] r_val [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && (r_count < c_DEPTH);
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: the count qualifies every read
  always_ff @(posedge clk) begin
    if (!rst && i_en && !i_flush && w_do_push) begin
      r_tag[r_wr_ptr] <= i_push_tag;
      r_val[r_wr_ptr] <= i_push_val;
    end
  end

  assign o_count    = r_count;
  assign o_head_tag = r_tag[r_rd_ptr];
  assign o_head_val = r_val[r_rd_ptr];

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Buffers results from execution units and round-robin drains one
//            per cycle into the ROB submit port; flushes on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = c_NUM_REQ,
  parameter int TAG_W     = c_TAG_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int BUF_DEPTH = c_BUF_DEPTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      predict_fail,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wb_valid,
  output logic [TAG_W-1:0]          wb_tag,
  output logic [DATA_W-1:0]         wb_val,
  output logic [1:0]                wb_src,
  input  logic                      wb_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(BUF_DEPTH);
  localparam logic [TAG_W-1:0] c_NULL     = TAG_W'(c_NULL_TAG);
  localparam logic [1:0]       c_LAST_REQ = 2'(NUM_REQ - 1);

  logic [CNT_W-1:0]  w_count    [NUM_REQ];
  logic [TAG_W-1:0]  w_head_tag [NUM_REQ];
  logic [DATA_W-1:0] w_head_val [NUM_REQ];
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop_sel;
  logic [NUM_REQ-1:0] w_cand;
  logic [1:0]         r_rr_ptr;
  logic [1:0]         w_grant;
  logic               w_any;
  logic               w_pop;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      // Registered count only: a same-cycle pop does not open a slot
      assign req_ready[i] = rdy_in && !rst_in && !predict_fail && (w_count[i] < c_DEPTH);
      assign w_push[i]    = req_valid[i] && req_ready[i] &&
                            (req_tag[i*TAG_W +: TAG_W] != c_NULL);
      assign w_cand[i]    = (w_count[i] != '0);
      assign w_pop_sel[i] = w_pop && (w_grant == 2'(i));

      wb_fifo #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
      ) u_fifo (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_en       (rdy_in),
        .i_flush    (predict_fail),
        .i_push     (w_push[i]),
        .i_push_tag (req_tag[i*TAG_W +: TAG_W]),
        .i_push_val (req_val[i*DATA_W +: DATA_W]),
        .i_pop      (w_pop_sel[i]),
        .o_count    (w_count[i]),
        .o_head_tag (w_head_tag[i]),
        .o_head_val (w_head_val[i])
      );
    end
  endgenerate

  // Scan in reverse so the last hit written is the first in rr order
  always_comb begin : p_grant
    logic [1:0] idx;
    idx     = '0;
    w_grant = '0;
    w_any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = 2'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (w_cand[idx]) begin
        w_grant = idx;
        w_any   = 1'b1;
      end
    end
  end

  assign wb_valid = rdy_in && !predict_fail && w_any;
  assign wb_tag   = wb_valid ? w_head_tag[w_grant] : '0;
  assign wb_val   = wb_valid ? w_head_val[w_grant] : '0;
  assign wb_src   = wb_valid ? w_grant : '0;
  assign w_pop    = wb_valid && wb_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr_ptr <= '0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        r_rr_ptr <= '0;
      end else if (w_pop) begin
        r_rr_ptr <= (w_grant == c_LAST_REQ) ? 2'd0 : w_grant + 2'd1;
      end
    end
  end

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Directed self-checking bench for wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        predict_fail;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_val;
  logic [2:0]  req_ready;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic [1:0]  wb_src;
  logic        wb_ready;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  wb_arbiter dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .predict_fail (predict_fail),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_val      (req_val),
    .req_ready    (req_ready),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_val       (wb_val),
    .wb_src       (wb_src),
    .wb_ready     (wb_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [3:0] t,
                        input logic [31:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(v));
    chk({tag, ".tag"},   32'(wb_tag),   32'(t));
    chk({tag, ".val"},   wb_val,        d);
    chk({tag, ".src"},   32'(wb_src),   32'(s));
  endtask

  // Advance one edge, then let inputs/outputs settle away from it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; predict_fail = 1'b0;
    req_valid = '0; req_tag = '0; req_val = '0; wb_ready = 1'b0;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    step();
    rst_in = 1'b0;
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'h7);
    chk_wb("idle_after_reset", 1'b0, 4'd0, 32'h0, 2'd0);

    // Single result from RS
    req_valid = 3'b001; req_tag = {4'd0, 4'd0, 4'd3}; req_val = {32'h0, 32'h0, 32'h11};
    wb_ready  = 1'b1;
    #1;
    chk("no_comb_path", 32'(wb_valid), 32'h0);
    step();
    req_valid = '0;
    #1;
    chk_wb("single", 1'b1, 4'd3, 32'h11, 2'd0);
    step();
    chk("single_drained", 32'(wb_valid), 32'h0);

    // Re-reset so rr_ptr starts at 0 for the collision case
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    req_valid = 3'b111; req_tag = {4'd3, 4'd2, 4'd1}; req_val = {32'ha3, 32'ha2, 32'ha1};
    step();
    req_valid = '0;
    #1;
    chk_wb("coll_0", 1'b1, 4'd1, 32'ha1, 2'd0);
    step();
    chk_wb("coll_1", 1'b1, 4'd2, 32'ha2, 2'd1);
    step();
    chk_wb("coll_2", 1'b1, 4'd3, 32'ha3, 2'd2);
    step();
    chk("coll_drained", 32'(wb_valid), 32'h0);
    req_valid = 3'b010; req_tag = {4'd0, 4'd7, 4'd0}; req_val = {32'h0, 32'h77, 32'h0};
    step();
    req_valid = '0;
    #1;
    chk_wb("lsb_after_wrap", 1'b1, 4'd7, 32'h77, 2'd1);
    step();
    chk("lsb_drained", 32'(wb_valid), 32'h0);

    // Backpressure fills the LSB FIFO
    wb_ready  = 1'b0;
    req_valid = 3'b010; req_tag = {4'd0, 4'd4, 4'd0}; req_val = {32'h0, 32'h44, 32'h0};
    step();
    chk("lsb_ready_one", 32'(req_ready[1]), 32'h1);
    req_tag = {4'd0, 4'd5, 4'd0}; req_val = {32'h0, 32'h55, 32'h0};
    step();
    req_valid = '0;
    #1;
    chk("lsb_full", 32'(req_ready[1]), 32'h0);
    chk_wb("bp_hold0", 1'b1, 4'd4, 32'h44, 2'd1);
    step();
    chk_wb("bp_hold1", 1'b1, 4'd4, 32'h44, 2'd1);
    wb_ready = 1'b1;
    step();
    chk("lsb_ready_after_pop", 32'(req_ready[1]), 32'h1);
    chk_wb("bp_second", 1'b1, 4'd5, 32'h55, 2'd1);
    step();
    chk("bp_drained", 32'(wb_valid), 32'h0);

    // Fill all FIFOs, then flush with a concurrent push attempt
    wb_ready  = 1'b0;
    req_valid = 3'b111; req_tag = {4'd3, 4'd2, 4'd1}; req_val = {32'hc3, 32'hc2, 32'hc1};
    step();
    req_tag = {4'd6, 4'd5, 4'd4};
    step();
    chk("all_full", 32'(req_ready), 32'h0);
    predict_fail = 1'b1; wb_ready = 1'b1;
    req_valid = 3'b001; req_tag = {4'd0, 4'd0, 4'd9}; req_val = {32'h0, 32'h0, 32'h99};
    #1;
    chk_wb("during_flush", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("ready_during_flush", 32'(req_ready), 32'h0);
    step();
    predict_fail = 1'b0; req_valid = '0;
    #1;
    chk_wb("after_flush", 1'b0, 4'd0, 32'h0, 2'd0);
    chk("ready_after_flush", 32'(req_ready), 32'h7);
    step();
    chk("flush_no_ghost", 32'(wb_valid), 32'h0);

    // Pause holds contents
    wb_ready  = 1'b0;
    req_valid = 3'b011; req_tag = {4'd0, 4'd9, 4'd8}; req_val = {32'h0, 32'h99, 32'h88};
    step();
    req_valid = '0;
    #1;
    chk_wb("pre_pause", 1'b1, 4'd8, 32'h88, 2'd0);
    rdy_in = 1'b0; wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_wb("paused", 1'b0, 4'd0, 32'h0, 2'd0);
      chk("paused_ready", 32'(req_ready), 32'h0);
      step();
    end
    rdy_in = 1'b1;
    #1;
    chk_wb("resume_head", 1'b1, 4'd8, 32'h88, 2'd0);
    step();
    chk_wb("resume_next", 1'b1, 4'd9, 32'h99, 2'd1);
    step();
    chk("resume_drained", 32'(wb_valid), 32'h0);

    // Null tag is accepted but never enqueued
    wb_ready  = 1'b0;
    req_valid = 3'b100; req_tag = {4'd0, 4'd0, 4'd0}; req_val = {32'hdead, 32'h0, 32'h0};
    #1;
    chk("null_ready", 32'(req_ready[2]), 32'h1);
    step();
    step();
    req_valid = '0;
    #1;
    chk("null_not_counted", 32'(req_ready[2]), 32'h1);
    chk_wb("null_absent", 1'b0, 4'd0, 32'h0, 2'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule : tb_wb_arbiter
`default_nettype wire
